sampling_layer_param: RTL and testbench



---
 rtl/sampling_layer_param.sv | 163 ++++++++++++++++
 tb/tb_sampling_layer_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sampling_layer_param.sv
// sampling_layer_param: multi-channel 2x2 / stride-2 pooling layer (max or average per frame).
//   Clock         - rising-edge clock
//   Input_Reset   - synchronous active-high reset
//   Mode          - 0 = max pool, 1 = average pool; latched on the first beat of a frame
//   Input_Valid   - Input_Pixels valid this cycle
//   Input_Finish  - abort strobe while a frame is running
//   Input_Pixels  - CH pixels, channel c at [c*DATA_W +: DATA_W]
//   Output_Pixels - pooled pixels, same packing; holds while Output_Valid is low
//   Output_Valid  - one-cycle pulse per pooled pixel
//   Output_Finish - one-cycle pulse at frame end or abort
//   Busy          - high while a frame is in progress
module sampling_layer_param #(
   parameter int unsigned CH     = 6,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned IMG_W  = 10,
   parameter int unsigned IMG_H  = 10
) (
   input  logic                 Clock,
   input  logic                 Input_Reset,
   input  logic                 Mode,
   input  logic                 Input_Valid,
   input  logic                 Input_Finish,
   input  logic [CH*DATA_W-1:0] Input_Pixels,
   output logic [CH*DATA_W-1:0] Output_Pixels,
   output logic                 Output_Valid,
   output logic                 Output_Finish,
   output logic                 Busy
);

   localparam int unsigned COL_W  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int unsigned ROW_W  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int unsigned LB_AW  = (COL_W > 1) ? COL_W - 1 : 1;
   localparam int unsigned LB_N   = 2 ** LB_AW;
   localparam int unsigned PAIR_W = DATA_W + 1;
   localparam int unsigned SUM_W  = DATA_W + 2;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   logic [COL_W-1:0]   col;
   logic [ROW_W-1:0]   row;
   logic               mode_r;

   logic signed [DATA_W-1:0] h  [CH];
   logic signed [PAIR_W-1:0] lb [CH][LB_N];

   logic                 accept_c;
   logic                 mode_c;
   logic                 emit_c;
   logic                 last_c;
   logic [LB_AW-1:0]     lb_idx_c;
   logic [CH*DATA_W-1:0] pooled_c;

   // Horizontal pair: max, or full-precision sum for averaging.
   function automatic logic signed [PAIR_W-1:0] pair_f(input logic avg,
                                                      input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
      logic signed [PAIR_W-1:0] r;
      if (avg) r = PAIR_W'(a) + PAIR_W'(b);
      else     r = (a > b) ? PAIR_W'(a) : PAIR_W'(b);
      return r;
   endfunction

   // Vertical combine of the buffered upper pair with the lower pair.
   function automatic logic [DATA_W-1:0] combine_f(input logic avg,
                                                   input logic signed [PAIR_W-1:0] u,
                                                   input logic signed [PAIR_W-1:0] l);
      logic signed [SUM_W-1:0]  s;
      logic signed [PAIR_W-1:0] m;
      logic [DATA_W-1:0]        r;
      s = SUM_W'(u) + SUM_W'(l);
      s = s >>> 2;
      m = (u > l) ? u : l;
      r = avg ? s[DATA_W-1:0] : m[DATA_W-1:0];
      return r;
   endfunction

   // A beat is consumed in IDLE, or in RUN when not aborting; DONE ignores input.
   assign accept_c = Input_Valid && ((state == IDLE) || ((state == RUN) && !Input_Finish));
   // The first beat pools with the Mode it carries; later beats use the latched mode.
   assign mode_c   = (state == IDLE) ? Mode : mode_r;
   assign emit_c   = accept_c && col[0] && row[0];
   assign last_c   = (col == COL_W'(IMG_W - 1)) && (row == ROW_W'(IMG_H - 1));
   assign lb_idx_c = LB_AW'(col >> 1);

   // Completed window result for every channel.
   always_comb begin
      pooled_c = '0;
      for (int c = 0; c < CH; c++) begin
         pooled_c[c*DATA_W +: DATA_W] =
            combine_f(mode_c, lb[c][lb_idx_c],
                      pair_f(mode_c, h[c], Input_Pixels[c*DATA_W +: DATA_W]));
      end
   end

   // Pixel holding register and line buffer; contents need no reset.
   always_ff @(posedge Clock) begin
      if (accept_c) begin
         for (int c = 0; c < CH; c++) begin
            if (!col[0])
               h[c] <= Input_Pixels[c*DATA_W +: DATA_W];
            else if (!row[0])
               lb[c][lb_idx_c] <= pair_f(mode_c, h[c], Input_Pixels[c*DATA_W +: DATA_W]);
         end
      end
   end

   // Frame FSM, raster counters and registered outputs.
   always_ff @(posedge Clock) begin
      if (Input_Reset) begin
         state         <= IDLE;
         col           <= '0;
         row           <= '0;
         mode_r        <= 1'b0;
         Output_Pixels <= '0;
         Output_Valid  <= 1'b0;
         Output_Finish <= 1'b0;
         Busy          <= 1'b0;
      end else begin
         Output_Valid  <= 1'b0;
         Output_Finish <= 1'b0;
         if (emit_c) begin
            Output_Valid  <= 1'b1;
            Output_Pixels <= pooled_c;
         end
         case (state)
            IDLE: begin
               if (Input_Valid) begin
                  state  <= RUN;
                  Busy   <= 1'b1;
                  mode_r <= Mode;
                  col    <= COL_W'(1);
               end
            end
            RUN: begin
               if (Input_Finish) begin
                  state         <= IDLE;
                  Busy          <= 1'b0;
                  col           <= '0;
                  row           <= '0;
                  Output_Finish <= 1'b1;
               end else if (Input_Valid) begin
                  if (last_c) begin
                     state         <= DONE;
                     Busy          <= 1'b0;
                     col           <= '0;
                     row           <= '0;
                     Output_Finish <= 1'b1;
                  end else if (col == COL_W'(IMG_W - 1)) begin
                     col <= '0;
                     row <= row + ROW_W'(1);
                  end else begin
                     col <= col + COL_W'(1);
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sampling_layer_param.sv
// tb_sampling_layer_param: directed bench for sampling_layer_param (CH=6, 16-bit, 10x10).
module tb_sampling_layer_param;

   localparam int CH = 6;
   localparam int DW = 16;
   localparam int W  = 10;
   localparam int H  = 10;
   localparam int PW = CH * DW;

   logic          Clock = 1'b0;
   logic          Input_Reset = 1'b1;
   logic          Mode = 1'b0;
   logic          Input_Valid = 1'b0;
   logic          Input_Finish = 1'b0;
   logic [PW-1:0] Input_Pixels = '0;
   logic [PW-1:0] Output_Pixels;
   logic          Output_Valid;
   logic          Output_Finish;
   logic          Busy;

   sampling_layer_param #(.CH(CH), .DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
      .Clock         (Clock),
      .Input_Reset   (Input_Reset),
      .Mode          (Mode),
      .Input_Valid   (Input_Valid),
      .Input_Finish  (Input_Finish),
      .Input_Pixels  (Input_Pixels),
      .Output_Pixels (Output_Pixels),
      .Output_Valid  (Output_Valid),
      .Output_Finish (Output_Finish),
      .Busy          (Busy)
   );

   always #5 Clock = ~Clock;

   logic signed [DW-1:0] img [CH][H][W];
   logic [PW-1:0]        out_q [$];
   logic [PW-1:0]        hold = '0;
   int                   errors = 0;
   int                   checks = 0;

   task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Reference pooled output computed straight from the four window pixels.
   function automatic logic [PW-1:0] model(input bit avg, input int i, input int j);
      logic [PW-1:0] v;
      int a, b, d, e, r;
      v = '0;
      for (int c = 0; c < CH; c++) begin
         a = int'(img[c][2*j][2*i]);
         b = int'(img[c][2*j][2*i+1]);
         d = int'(img[c][2*j+1][2*i]);
         e = int'(img[c][2*j+1][2*i+1]);
         if (avg) r = (a + b + d + e) >>> 2;
         else begin
            r = a;
            if (b > r) r = b;
            if (d > r) r = d;
            if (e > r) r = e;
         end
         v[c*DW +: DW] = 16'(r);
      end
      return v;
   endfunction

   function automatic logic [PW-1:0] pack(input int k);
      logic [PW-1:0] p;
      for (int c = 0; c < CH; c++) p[c*DW +: DW] = img[c][k / W][k % W];
      return p;
   endfunction

   task automatic fill_ramp();
      for (int c = 0; c < CH; c++)
         for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
               img[c][y][x] = 16'(c * 100 + y * 10 + x);
   endtask

   // Drives one frame; abort_at / reset_at give the beat index of an abort or reset (-1 = none).
   task automatic run_frame(input bit mode, input int gap_pct, input int abort_at,
                            input int reset_at, input bit toggle);
      int  x, y;
      bit  expv;
      logic [PW-1:0] e;
      out_q.delete();
      for (int k = 0; k < W * H; k++) begin
         if (k > 0) begin
            while ($urandom_range(99) < gap_pct) begin
               Input_Valid  = 1'b0;
               Input_Pixels = {$urandom, $urandom, $urandom};
               tick();
               check("stall_valid", PW'(Output_Valid), PW'(0));
               check("stall_hold", Output_Pixels, hold);
               check("stall_busy", PW'(Busy), PW'(1));
            end
         end
         Mode         = (toggle && k > 0) ? ~mode : mode;
         Input_Pixels = pack(k);
         Input_Valid  = 1'b1;
         if (k == abort_at) begin
            Input_Finish = 1'b1;
            tick();
            Input_Finish = 1'b0;
            Input_Valid  = 1'b0;
            check("abort_valid", PW'(Output_Valid), PW'(0));
            check("abort_finish", PW'(Output_Finish), PW'(1));
            check("abort_busy", PW'(Busy), PW'(0));
            tick();
            check("abort_finish_drop", PW'(Output_Finish), PW'(0));
            return;
         end
         if (k == reset_at) begin
            Input_Reset = 1'b1;
            tick();
            Input_Reset = 1'b0;
            Input_Valid = 1'b0;
            check("rst_pixels", Output_Pixels, PW'(0));
            check("rst_valid", PW'(Output_Valid), PW'(0));
            check("rst_finish", PW'(Output_Finish), PW'(0));
            check("rst_busy", PW'(Busy), PW'(0));
            hold = '0;
            tick();
            check("rst_no_finish", PW'(Output_Finish), PW'(0));
            return;
         end
         tick();
         x    = k % W;
         y    = k / W;
         expv = (x % 2 == 1) && (y % 2 == 1);
         check("out_valid", PW'(Output_Valid), PW'(expv));
         if (expv) begin
            e = model(mode, x / 2, y / 2);
            check("out_pixels", Output_Pixels, e);
            hold = e;
            out_q.push_back(Output_Pixels);
         end
         check("out_finish", PW'(Output_Finish), PW'(k == W * H - 1));
         check("busy", PW'(Busy), PW'(k != W * H - 1));
      end
      // DONE cycle: an offered beat must be ignored.
      Input_Valid  = 1'b1;
      Input_Pixels = pack(0);
      tick();
      Input_Valid = 1'b0;
      check("done_busy", PW'(Busy), PW'(0));
      check("done_valid", PW'(Output_Valid), PW'(0));
      check("done_finish", PW'(Output_Finish), PW'(0));
      tick();
      check("idle_busy", PW'(Busy), PW'(0));
      check("frame_count", PW'(out_q.size()), PW'(25));
   endtask

   initial begin
      logic [PW-1:0] t;
      Input_Reset = 1'b1;
      tick();
      tick();
      check("reset_pixels", Output_Pixels, PW'(0));
      check("reset_valid", PW'(Output_Valid), PW'(0));
      check("reset_finish", PW'(Output_Finish), PW'(0));
      check("reset_busy", PW'(Busy), PW'(0));
      Input_Reset = 1'b0;
      tick();

      // Max pool ramp frame, no gaps.
      fill_ramp();
      run_frame(1'b0, 0, -1, -1, 1'b0);
      if (out_q.size() == 25) begin
         t = out_q[0];
         check("t1_first_ch2", PW'(t[2*DW +: DW]), PW'(16'd211));
         t = out_q[24];
         check("t1_last_ch5", PW'(t[5*DW +: DW]), PW'(16'd599));
      end

      // Average pool with negative-floor and extreme-value windows.
      for (int c = 0; c < CH; c++)
         for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
               img[c][y][x] = 16'($urandom);
      img[0][0][0] = -16'sd3;
      img[0][0][1] = -16'sd2;
      img[0][1][0] = -16'sd1;
      img[0][1][1] = -16'sd1;
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 2; x++) begin
            img[1][y][x] = 16'sh7FFF;
            img[2][y][x] = 16'sh8000;
         end
      run_frame(1'b1, 0, -1, -1, 1'b0);
      if (out_q.size() == 25) begin
         t = out_q[0];
         check("t2_floor_neg", PW'(t[0 +: DW]), PW'(16'hFFFE));
         check("t2_max_pos", PW'(t[DW +: DW]), PW'(16'h7FFF));
         check("t2_max_neg", PW'(t[2*DW +: DW]), PW'(16'h8000));
      end

      // Random valid gaps in both modes.
      fill_ramp();
      run_frame(1'b0, 50, -1, -1, 1'b0);
      run_frame(1'b1, 50, -1, -1, 1'b0);

      // Abort at the third row, sixth column: only the first window row completes.
      run_frame(1'b0, 0, 2 * W + 5, -1, 1'b0);
      check("t4_abort_count", PW'(out_q.size()), PW'(5));
      run_frame(1'b1, 0, -1, -1, 1'b0);

      // Reset in row 6, then a full frame.
      run_frame(1'b0, 30, -1, 6 * W + 3, 1'b0);
      run_frame(1'b0, 0, -1, -1, 1'b0);

      // Mode toggled mid-frame, then the new mode on the next frame.
      run_frame(1'b0, 0, -1, -1, 1'b1);
      run_frame(1'b1, 0, -1, -1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
